// File: rtl/ustc_dn_ctrl.sv
// ustc_dn_ctrl: issue controller for the sparse-core distribution network.
//
// Accepts one dense operand vector plus a tile length. It then streams that
// tile's index words into the network, one per cycle. Issue is throttled by a
// credit counter that tracks the downstream buffer. A {vld,last} tag follows
// each issue through the network latency, so consumers know when each output
// word is valid and when the tile is complete.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// Ready never depends on valid: d_ready and m_ready are decoded from
// registered state only. An offered word may wait any number of cycles for
// ready.
//
// Ports
//   clk, reset      clock; asynchronous active-low reset
//   d_valid/d_ready tile handshake (d_data operand vector, d_len word count)
//   m_valid/m_ready index-word handshake (m_idx)
//   dn_in, dn_idx   operand vector / index word driven to the network
//   dn_vld          dn_idx carries a new issue this cycle
//   o_vld, o_last   network output valid / last word of tile (dn_vld + DN_LAT)
//   tile_done       one-cycle pulse at tile completion
//   cr_ret          downstream frees one buffer slot
//   cr_err          sticky: credit returned while the counter was full
//   dbg_state       FSM state (0 IDLE, 1 ISSUE, 2 DRAIN)
//   dbg_credit      current credit count
module ustc_dn_ctrl #(
  parameter int DW_DATA = 8,
  parameter int DW_IDX  = 3,
  parameter int N_IN    = 8,
  parameter int N_OUT   = 32,
  parameter int DN_LAT  = 2,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          d_valid,
  output logic                          d_ready,
  input  logic [N_IN*DW_DATA-1:0]       d_data,
  input  logic [CNT_W-1:0]              d_len,
  input  logic                          m_valid,
  output logic                          m_ready,
  input  logic [N_OUT*DW_IDX-1:0]       m_idx,
  output logic [N_IN*DW_DATA-1:0]       dn_in,
  output logic [N_OUT*DW_IDX-1:0]       dn_idx,
  output logic                          dn_vld,
  output logic                          o_vld,
  output logic                          o_last,
  output logic                          tile_done,
  input  logic                          cr_ret,
  output logic                          cr_err,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(CREDITS+1)-1:0]  dbg_credit
);

  localparam int CR_W = $clog2(CREDITS + 1);
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(CREDITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CR_W-1:0]           credit_q, credit_d;
  logic                      cr_err_q, cr_err_d;
  logic [N_IN*DW_DATA-1:0]   dn_in_q, dn_in_d;
  logic [N_OUT*DW_IDX-1:0]   dn_idx_q, dn_idx_d;
  logic                      dn_vld_q, dn_vld_d;
  logic                      last_q, last_d;       // tag: current dn_vld is the tile's last
  logic                      zl_done_q, zl_done_d; // zero-length tile completion
  logic [DN_LAT-1:0]         vld_pipe_q;
  logic [DN_LAT-1:0]         last_pipe_q;

  logic d_hs;
  logic m_hs;
  logic tail_out;

  // Final tag stage: valid word that closes the tile.
  assign tail_out = vld_pipe_q[DN_LAT-1] & last_pipe_q[DN_LAT-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dn_in_d   = dn_in_q;
    dn_idx_d  = dn_idx_q;
    dn_vld_d  = 1'b0;
    last_d    = 1'b0;
    zl_done_d = 1'b0;

    d_ready = (state_q == IDLE);
    m_ready = (state_q == ISSUE) && (credit_q != '0);
    d_hs    = d_valid & d_ready;
    m_hs    = m_valid & m_ready;

    case (state_q)
      IDLE: begin
        if (d_hs) begin
          dn_in_d = d_data;
          cnt_d   = d_len;
          if (d_len != '0) begin
            state_d = ISSUE;
          end else begin
            zl_done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (m_hs) begin
          dn_idx_d = m_idx;
          dn_vld_d = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            last_d  = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (tail_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counter: an issue and a return in the same cycle cancel out. A
  // return into a full counter is dropped and recorded as an error.
  always_comb begin
    credit_d = credit_q;
    cr_err_d = cr_err_q;
    if (m_hs && !cr_ret) begin
      credit_d = credit_q - CR_W'(1);
    end else if (cr_ret && !m_hs) begin
      if (credit_q == CR_MAX) begin
        cr_err_d = 1'b1;
      end else begin
        credit_d = credit_q + CR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      credit_q  <= CR_MAX;
      cr_err_q  <= 1'b0;
      dn_in_q   <= '0;
      dn_idx_q  <= '0;
      dn_vld_q  <= 1'b0;
      last_q    <= 1'b0;
      zl_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      credit_q  <= credit_d;
      cr_err_q  <= cr_err_d;
      dn_in_q   <= dn_in_d;
      dn_idx_q  <= dn_idx_d;
      dn_vld_q  <= dn_vld_d;
      last_q    <= last_d;
      zl_done_q <= zl_done_d;
    end
  end

  // Tag pipeline models the network latency. It starts at dn_vld, so o_vld
  // lands DN_LAT cycles after dn_vld.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q[0]  <= dn_vld_q;
      last_pipe_q[0] <= last_q;
      for (int i = 1; i < DN_LAT; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
    end
  end

  assign dn_in      = dn_in_q;
  assign dn_idx     = dn_idx_q;
  assign dn_vld     = dn_vld_q;
  assign o_vld      = vld_pipe_q[DN_LAT-1];
  assign o_last     = last_pipe_q[DN_LAT-1];
  assign cr_err     = cr_err_q;
  // Completion is either the deferred zero-length pulse or the last tag
  // leaving the network while draining.
  assign tile_done  = zl_done_q | ((state_q == DRAIN) & tail_out);
  assign dbg_state  = state_q;
  assign dbg_credit = credit_q;

endmodule

// File: tb/tb_ustc_dn_ctrl.sv
// Directed testbench for ustc_dn_ctrl (default parameters).
module tb_ustc_dn_ctrl;

  localparam int DW = 64;  // N_IN*DW_DATA
  localparam int IW = 96;  // N_OUT*DW_IDX

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          d_valid;
  logic          d_ready;
  logic [DW-1:0] d_data;
  logic [7:0]    d_len;
  logic          m_valid;
  logic          m_ready;
  logic [IW-1:0] m_idx;
  logic [DW-1:0] dn_in;
  logic [IW-1:0] dn_idx;
  logic          dn_vld;
  logic          o_vld;
  logic          o_last;
  logic          tile_done;
  logic          cr_ret;
  logic          cr_err;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_credit;

  ustc_dn_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .d_data     (d_data),
    .d_len      (d_len),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_idx      (m_idx),
    .dn_in      (dn_in),
    .dn_idx     (dn_idx),
    .dn_vld     (dn_vld),
    .o_vld      (o_vld),
    .o_last     (o_last),
    .tile_done  (tile_done),
    .cr_ret     (cr_ret),
    .cr_err     (cr_err),
    .dbg_state  (dbg_state),
    .dbg_credit (dbg_credit)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [IW-1:0] exp_q[$];
  int n_dn_vld = 0;
  int n_o_vld  = 0;
  int n_o_last = 0;
  int n_done   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every issue must match the next expected index word. Output tags are
  // counted for the end-of-run totals.
  always @(negedge clk) begin
    if (dn_vld) begin
      n_dn_vld++;
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 1, 0);
      end else begin
        chk("dn_idx_stream", dn_idx, exp_q.pop_front());
      end
    end
    if (o_vld) n_o_vld++;
    if (o_vld && o_last) n_o_last++;
    if (tile_done) n_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [DW-1:0] data, input logic [7:0] len);
    d_valid = 1'b1;
    d_data  = data;
    d_len   = len;
    tick();
    d_valid = 1'b0;
  endtask

  task automatic issue(input logic [IW-1:0] w);
    m_valid = 1'b1;
    m_idx   = w;
    exp_q.push_back(w);
    tick();
  endtask

  task automatic ret_credits(input int n);
    cr_ret = 1'b1;
    repeat (n) tick();
    cr_ret = 1'b0;
  endtask

  function automatic logic [IW-1:0] rep(input logic [23:0] g);
    return {4{g}};
  endfunction

  // {6,4,5,2,1,7,2,0} and identity {7..0}, element 0 in the LSBs
  localparam logic [23:0] G_A  = 24'hD2A3D0;
  localparam logic [23:0] G_ID = 24'hFAC688;
  localparam logic [DW-1:0] VEC0 = 64'h0706050403020100;

  logic [IW-1:0] wtab[6];
  int o_snap;
  int d_snap;
  int s_snap;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    d_valid = 1'b0;
    d_data  = '0;
    d_len   = '0;
    m_valid = 1'b0;
    m_idx   = '0;
    cr_ret  = 1'b0;
    for (int i = 0; i < 6; i++) wtab[i] = rep(24'h111111 * (i + 1));
    tick();
    tick();

    // ---- reset state ----
    chk("rst_dn_in", dn_in, 0);
    chk("rst_dn_idx", dn_idx, 0);
    chk("rst_dn_vld", dn_vld, 0);
    chk("rst_o_vld", o_vld, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_tile_done", tile_done, 0);
    chk("rst_cr_err", cr_err, 0);
    chk("rst_credit", dbg_credit, 4);
    chk("rst_d_ready", d_ready, 1);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b1;
    tick();

    // ---- basic tile ----
    start_tile(VEC0, 8'd2);
    chk("b_dn_in", dn_in, VEC0);
    chk("b_state_issue", dbg_state, 1);
    chk("b_d_ready", d_ready, 0);
    chk("b_m_ready", m_ready, 1);
    issue(rep(G_A));
    chk("b_dn_idx0", dn_idx, rep(G_A));
    chk("b_dn_vld0", dn_vld, 1);
    chk("b_credit3", dbg_credit, 3);
    issue(rep(G_ID));
    m_valid = 1'b0;
    chk("b_dn_idx1", dn_idx, rep(G_ID));
    chk("b_state_drain", dbg_state, 2);
    chk("b_credit2", dbg_credit, 2);
    chk("b_m_ready_drain", m_ready, 0);
    chk("b_o_vld_early", o_vld, 0);
    tick();
    chk("b_o_vld0", o_vld, 1);
    chk("b_o_last0", o_last, 0);
    chk("b_done0", tile_done, 0);
    chk("b_dn_vld_gap", dn_vld, 0);
    chk("b_dn_in_hold", dn_in, VEC0);
    tick();
    chk("b_o_vld1", o_vld, 1);
    chk("b_o_last1", o_last, 1);
    chk("b_done1", tile_done, 1);
    tick();
    chk("b_idle", dbg_state, 0);
    chk("b_d_ready_back", d_ready, 1);
    chk("b_o_vld_off", o_vld, 0);
    chk("b_done_off", tile_done, 0);
    ret_credits(2);
    chk("b_credit_back", dbg_credit, 4);

    // ---- zero length ----
    d_snap = n_dn_vld;
    start_tile(64'hA5A5_0000_1234_5678, 8'd0);
    chk("z_done", tile_done, 1);
    chk("z_state", dbg_state, 0);
    chk("z_dn_in", dn_in, 64'hA5A5_0000_1234_5678);
    chk("z_dn_vld", dn_vld, 0);
    chk("z_d_ready", d_ready, 1);
    tick();
    chk("z_done_off", tile_done, 0);
    tick();
    chk("z_no_issue", n_dn_vld, d_snap);

    // ---- credit stall ----
    start_tile(64'h1111_2222_3333_4444, 8'd6);
    for (int i = 0; i < 4; i++) issue(wtab[i]);
    chk("c_credit0", dbg_credit, 0);
    chk("c_m_ready0", m_ready, 0);
    m_idx = wtab[4];
    tick();
    chk("c_stall_vld_a", dn_vld, 0);
    tick();
    chk("c_stall_vld_b", dn_vld, 0);
    chk("c_stall_state", dbg_state, 1);
    cr_ret = 1'b1;
    tick();
    cr_ret = 1'b0;
    chk("c_credit1", dbg_credit, 1);
    chk("c_m_ready1", m_ready, 1);
    exp_q.push_back(wtab[4]);
    tick();
    chk("c_issue5", dn_vld, 1);
    chk("c_credit0b", dbg_credit, 0);
    m_idx  = wtab[5];
    cr_ret = 1'b1;
    tick();
    cr_ret = 1'b0;
    chk("c_stall_vld_c", dn_vld, 0);
    chk("c_credit1b", dbg_credit, 1);
    exp_q.push_back(wtab[5]);
    tick();
    m_valid = 1'b0;
    chk("c_issue6", dn_idx, wtab[5]);
    chk("c_drain", dbg_state, 2);
    tick();
    tick();
    chk("c_done", tile_done, 1);
    tick();
    ret_credits(4);
    chk("c_credit_full", dbg_credit, 4);
    chk("c_cr_err0", cr_err, 0);

    // ---- simultaneous events ----
    start_tile(64'h0F0E0D0C0B0A0908, 8'd2);
    m_valid = 1'b1;
    m_idx   = rep(24'h5A5A5A);
    exp_q.push_back(rep(24'h5A5A5A));
    cr_ret  = 1'b1;
    tick();
    cr_ret = 1'b0;
    chk("s_credit_same", dbg_credit, 4);
    chk("s_cr_err_same", cr_err, 0);
    chk("s_dn_vld", dn_vld, 1);
    issue(rep(24'h0C0FFE));
    m_valid = 1'b0;
    chk("s_credit3", dbg_credit, 3);
    tick();
    tick();
    chk("s_done", tile_done, 1);
    tick();
    cr_ret = 1'b1;
    tick();
    chk("s_credit4", dbg_credit, 4);
    chk("s_cr_err_no", cr_err, 0);
    tick();
    cr_ret = 1'b0;
    chk("s_credit_sat", dbg_credit, 4);
    chk("s_cr_err_set", cr_err, 1);
    tick();
    chk("s_cr_err_sticky", cr_err, 1);

    // ---- gaps and back-to-back tiles ----
    start_tile(64'hDEAD_BEEF_0BAD_F00D, 8'd3);
    issue(rep(24'h123456));
    m_valid = 1'b0;
    tick();
    chk("g_gap0", dn_vld, 0);
    issue(rep(24'h654321));
    m_valid = 1'b0;
    chk("g_issue1", dn_idx, rep(24'h654321));
    tick();
    chk("g_gap1", dn_vld, 0);
    chk("g_credit2", dbg_credit, 2);
    issue(rep(24'hABCDEF));
    m_valid = 1'b0;
    chk("g_drain", dbg_state, 2);
    d_valid = 1'b1;
    d_data  = 64'hCAFE_F00D_1357_2468;
    d_len   = 8'd1;
    tick();
    tick();
    chk("g_done", tile_done, 1);
    chk("g_d_ready_done", d_ready, 0);
    tick();
    chk("g_d_ready_next", d_ready, 1);
    chk("g_dn_in_old", dn_in, 64'hDEAD_BEEF_0BAD_F00D);
    tick();
    d_valid = 1'b0;
    chk("g_dn_in_new", dn_in, 64'hCAFE_F00D_1357_2468);
    chk("g_state2", dbg_state, 1);
    issue(rep(24'h777000));
    m_valid = 1'b0;
    chk("g_credit_last", dbg_credit, 0);
    tick();
    tick();
    chk("g_done2", tile_done, 1);
    tick();
    ret_credits(4);

    // ---- reset mid-tile ----
    start_tile(64'h0102030405060708, 8'd3);
    issue(rep(24'h246813));
    m_valid = 1'b0;
    o_snap = n_o_vld;
    s_snap = n_done;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("r_dn_in", dn_in, 0);
    chk("r_dn_idx", dn_idx, 0);
    chk("r_dn_vld", dn_vld, 0);
    chk("r_credit", dbg_credit, 4);
    chk("r_cr_err", cr_err, 0);
    chk("r_d_ready", d_ready, 1);
    chk("r_m_ready", m_ready, 0);
    chk("r_state", dbg_state, 0);
    tick();
    reset = 1'b1;
    repeat (6) tick();
    chk("r_no_o_vld", n_o_vld, o_snap);
    chk("r_no_done", n_done, s_snap);
    chk("r_d_ready_after", d_ready, 1);

    // ---- totals ----
    chk("t_exp_q_empty", exp_q.size(), 0);
    chk("t_dn_vld", n_dn_vld, 15);
    chk("t_o_vld", n_o_vld, 14);
    chk("t_o_last", n_o_last, 5);
    chk("t_done", n_done, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ustc_dn_ctrl.md
# ustc_dn_ctrl

Issue controller for the sparse-core distribution network (`ustc_dn`). It accepts one dense operand vector per tile plus a length, then streams that tile's index words into the network one per cycle. Issue is throttled by a credit counter for the downstream buffer. A valid/last tag is tracked through the network latency so consumers know when each output word and each tile complete.

## Interface
Parameters:
- `DW_DATA` = 8: operand element width.
- `DW_IDX` = 3: index width; selects one of 2^DW_IDX inputs.
- `N_IN` = 8: operand elements per vector.
- `N_OUT` = 32: network outputs, i.e. indices per index word.
- `DN_LAT` = 2: cycles from `dn_vld` to the network output being valid. Must be ≥ 1.
- `CREDITS` = 4: downstream buffer slots.
- `CNT_W` = 8: tile-length width.

Ports:
- `clk` input 1: clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low (0 = reset).
- `d_valid` input 1: operand vector and length offered.
- `d_ready` output 1: controller accepts a tile.
- `d_data` input N_IN*DW_DATA: operand vector; element 0 in the LSBs.
- `d_len` input CNT_W: index words in the tile.
- `m_valid` input 1: index word offered.
- `m_ready` output 1: index word accepted.
- `m_idx` input N_OUT*DW_IDX: index word; output 0 in the LSBs.
- `dn_in` output N_IN*DW_DATA: operand vector driven to the network.
- `dn_idx` output N_OUT*DW_IDX: index word driven to the network.
- `dn_vld` output 1: `dn_idx` is a new issue this cycle.
- `o_vld` output 1: network output valid this cycle (`dn_vld` delayed by DN_LAT).
- `o_last` output 1: with `o_vld`, marks the last word of the tile.
- `tile_done` output 1: one-cycle pulse at tile completion.
- `cr_ret` input 1: downstream frees one slot.
- `cr_err` output 1: sticky flag; a credit return arrived while the counter was full.

## Operation
- FSM states: IDLE, ISSUE, DRAIN. Reset state is IDLE.
- IDLE:
  - `d_ready`=1.
  - On a `d_valid`&`d_ready` handshake, register `d_data` into `dn_in` and `d_len` into `cnt`.
  - If `d_len`≠0, go to ISSUE.
  - If `d_len`=0, stay in IDLE and pulse `tile_done` the next cycle. No issue occurs.
- ISSUE:
  - `m_ready` = (`credit`≠0), combinational from registered state.
  - On an `m_valid`&`m_ready` handshake:
    - `dn_idx`<=`m_idx`, `dn_vld`<=1.
    - `credit` decrements.
    - `cnt` decrements.
    - If `cnt`=1 before the decrement, tag the issue as last and go to DRAIN.
  - With no handshake, `dn_vld`<=0 and `dn_idx` holds.
- DRAIN:
  - `m_ready`=0, `d_ready`=0.
  - When `o_vld`&`o_last`, pulse `tile_done` in that same cycle and go to IDLE next cycle.
- `d_ready` is 0 in ISSUE and DRAIN. `m_ready` is 0 in IDLE and DRAIN.
- `dn_in` is stable for the entire tile and changes only on a `d` handshake.
- Tag pipeline: DN_LAT-stage shift register of {vld, last}, fed by {`dn_vld`, issued-last}. `o_vld`/`o_last` are the final stage.
- Credit counter:
  - Width clog2(CREDITS+1); reset value CREDITS.
  - Issue without `cr_ret`: −1. `cr_ret` without issue: +1. Both in the same cycle: unchanged.
  - `cr_ret` while `credit`=CREDITS and no issue: counter holds and `cr_err` sets. `cr_err` clears only on reset.
  - `credit`=0 forces `m_ready`=0. The counter never underflows.
  - `cr_ret` is honored in every state.
- Credits persist across tiles.

## Timing
- Reset values:
  - All registered outputs are 0: `dn_in`, `dn_idx`, `dn_vld`, `o_vld`, `o_last`, `tile_done`, `cr_err`.
  - `credit`=CREDITS, `cnt`=0, tag pipeline cleared.
  - Combinational outputs: `d_ready`=1, `m_ready`=0.
- A `d` handshake at cycle T puts the FSM in ISSUE at T+1. The earliest `m` handshake is at T+1.
- An `m` handshake at cycle t gives `dn_idx`/`dn_vld` at t+1 and `o_vld` at t+1+DN_LAT.
- Sustained throughput is 1 index word per cycle while `credit`>0 and `m_valid`=1.
- A `credit` decrement is visible the cycle after the issue. With no returns, exactly CREDITS back-to-back issues occur, then `m_ready` drops.
- `tile_done` coincides with `o_vld`&`o_last`. The next tile's `d_ready` rises the following cycle.
- When `d_len`=0, `tile_done` comes 1 cycle after the handshake.
- Reset asserted mid-tile:
  - All state returns to reset values immediately.
  - In-flight tags are discarded: no `o_vld` and no `tile_done` for the aborted tile.
  - The partial index stream is the upstream's responsibility.

## Test plan
- **Basic tile.** After reset, `d_data`={7,6,5,4,3,2,1,0} with `d_len`=2, then two index words: all-`{6,4,5,2,1,7,2,0}` repeated, then identity {7..0} repeated.
  - `dn_in` holds the vector.
  - `dn_idx` follows the two words on consecutive cycles.
  - `o_vld` is high for 2 cycles, DN_LAT after each issue; `o_last` on the second.
  - `tile_done` with `o_last`.
- **Zero length.** `d_len`=0 → no `dn_vld`, `tile_done` 1 cycle after the handshake, FSM stays in IDLE.
- **Credit stall.** `d_len`=6, `m_valid` held high, no `cr_ret` → 4 issues, `m_ready`=0. Pulse `cr_ret` twice → exactly 2 more issues, tile completes.
- **Simultaneous events.**
  - `cr_ret` on an issue cycle → `credit` unchanged.
  - `cr_ret` with `credit`=4 → `credit` stays 4 and `cr_err`=1.
- **Gaps and back-to-back tiles.** `m_valid` toggles every other cycle → issues only on handshakes, `dn_vld` is 0 in gaps. A second tile is accepted the cycle after `tile_done`, and its `dn_in` updates.
- **Reset mid-tile.** Assert `reset` after 1 of 3 issues → all outputs 0, `credit`=4, no subsequent `o_vld` or `tile_done`, `d_ready`=1.
